segre_mem_responder: RTL and testbench



---
 rtl/segre_mem_responder.sv | 127 ++++++++++++
 tb/tb_segre_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_responder.sv
// segre_mem_responder: fixed-latency line memory model.
// Byte/half/word writes into a line, full-line reads, one request in flight.

package segre_mem_pkg;
   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } memop_data_type_e;
endpackage

module segre_mem_responder
   import segre_mem_pkg::*;
#(
   parameter int unsigned MEM_LATENCY           = 5,
   parameter int unsigned MEM_DEPTH_LINES       = 1024,
   parameter int unsigned ADDR_SIZE             = 32,
   parameter int unsigned CACHE_LINE_SIZE_BYTES = 16,
   parameter string       INIT_FILE             = ""
) (
   input  logic                                  clk_i,
   input  logic                                  rsn_i,
   input  logic [ADDR_SIZE-1:0]                  addr_i,
   input  logic                                  mem_rd_i,
   input  logic                                  mem_wr_i,
   input  memop_data_type_e                      mem_data_type_i,
   input  logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] mem_wr_data_i,
   output logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] mem_rd_data_o,
   output logic                                  mem_ready_o,
   output logic                                  busy_o
);

   localparam int OFF_W = $clog2(CACHE_LINE_SIZE_BYTES);
   localparam int IDX_W = $clog2(MEM_DEPTH_LINES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] line_t;

   logic [1:0]       state_q;
   logic [7:0]       cnt_q;
   logic             wr_q;
   memop_data_type_e ty_q;
   logic [OFF_W-1:0] off_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   line_t            wdata_q;
   line_t            hold_q;
   line_t            resp_line;
   logic             accept;
   int               nbytes;

   line_t mem [MEM_DEPTH_LINES];

   // Line number wraps modulo the depth; no out-of-range error exists.
   assign idx_d = IDX_W'(addr_i[ADDR_SIZE-1:OFF_W] % MEM_DEPTH_LINES);

   assign accept      = (state_q == IDLE) && (mem_rd_i || mem_wr_i);
   assign mem_ready_o = (state_q == RESP);
   assign busy_o      = (state_q != IDLE);
   assign mem_rd_data_o = mem_ready_o ? resp_line : hold_q;

   // Response line: the stored line with captured write lanes merged in.
   always_comb begin
      resp_line = mem[idx_q];
      case (ty_q)
         HALF:    nbytes = 2;
         WORD:    nbytes = 4;
         default: nbytes = 1;
      endcase
      if (wr_q) begin
         for (int b = 0; b < int'(CACHE_LINE_SIZE_BYTES); b++) begin
            if (b >= int'(off_q) && b < int'(off_q) + nbytes) begin
               resp_line[b] = wdata_q[b];
            end
         end
      end
   end

   // Request FSM: accept in IDLE, count latency in BUSY, pulse in RESP.
   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= (MEM_LATENCY == 1) ? RESP : BUSY;
                  cnt_q   <= 8'(MEM_LATENCY - 1);
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
               hold_q  <= resp_line;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Capture the request at accept; later input changes are ignored.
   always_ff @(posedge clk_i) begin
      if (!rsn_i && accept) begin
         wr_q    <= mem_wr_i;
         ty_q    <= mem_data_type_i;
         off_q   <= addr_i[OFF_W-1:0];
         idx_q   <= idx_d;
         wdata_q <= mem_wr_data_i;
      end
   end

   // Commit a write at the end of its response cycle unless reset aborts it.
   always_ff @(posedge clk_i) begin
      if (!rsn_i && state_q == RESP && wr_q) begin
         mem[idx_q] <= resp_line;
      end
   end

endmodule

// File: tb/tb_segre_mem_responder.sv
// tb_segre_mem_responder: scoreboard bench with a byte-level memory model.
// Covers latency, merge/truncate, wrap, hold-high, reset abort, latency 1.

module tb_segre_mem_responder;
   import segre_mem_pkg::*;

   localparam int L     = 5;
   localparam int LB    = 16;
   localparam int DEPTH = 1024;
   localparam int BASE1 = 1 << 20;

   typedef logic [LB-1:0][7:0] line_t;
   typedef struct {
      line_t data;
      int    cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rsn = 1'b1;

   logic [31:0]      addr = '0;
   logic             rd = 1'b0;
   logic             wr = 1'b0;
   memop_data_type_e ty = BYTE;
   line_t            wd = '0;
   line_t            rdat;
   logic             rdy;
   logic             bsy;

   logic [31:0]      addr1 = '0;
   logic             rd1 = 1'b0;
   logic             wr1 = 1'b0;
   memop_data_type_e ty1 = BYTE;
   line_t            wd1 = '0;
   line_t            rdat1;
   logic             rdy1;
   logic             bsy1;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q[$];
   exp_t mon_e;
   logic [7:0] mdl [int];

   segre_mem_responder #(.MEM_LATENCY(L)) u_dut (
      .clk_i(clk), .rsn_i(rsn), .addr_i(addr),
      .mem_rd_i(rd), .mem_wr_i(wr), .mem_data_type_i(ty),
      .mem_wr_data_i(wd), .mem_rd_data_o(rdat),
      .mem_ready_o(rdy), .busy_o(bsy)
   );

   segre_mem_responder #(.MEM_LATENCY(1)) u_dut1 (
      .clk_i(clk), .rsn_i(rsn), .addr_i(addr1),
      .mem_rd_i(rd1), .mem_wr_i(wr1), .mem_data_type_i(ty1),
      .mem_wr_data_i(wd1), .mem_rd_data_o(rdat1),
      .mem_ready_o(rdy1), .busy_o(bsy1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(bit ok, string nm,
                               logic [127:0] act, logic [127:0] want);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, want);
   endfunction

   function automatic int line_of(logic [31:0] a);
      return int'((a >> 4) % DEPTH);
   endfunction

   function automatic int size_of(memop_data_type_e t);
      case (t)
         BYTE:    return 1;
         HALF:    return 2;
         default: return 4;
      endcase
   endfunction

   // Apply one request to the model; return the line the DUT must show.
   function automatic line_t model(int base, bit w, memop_data_type_e t,
                                   logic [31:0] a, line_t d);
      int    ln  = line_of(a);
      int    off = int'(a[3:0]);
      int    k;
      line_t r;
      if (w) begin
         for (int i = 0; i < size_of(t); i++) begin
            if (off + i < LB) mdl[base + ln * LB + off + i] = d[off + i];
         end
      end
      for (int b = 0; b < LB; b++) begin
         k = base + ln * LB + b;
         r[b] = mdl.exists(k) ? mdl[k] : 8'hxx;
      end
      return r;
   endfunction

   function automatic line_t rnd_line();
      line_t r;
      for (int i = 0; i < LB / 4; i++) r[i*4 +: 4] = $urandom;
      return r;
   endfunction

   function automatic memop_data_type_e rnd_ty();
      case ($urandom_range(0, 2))
         0:       return BYTE;
         1:       return HALF;
         default: return WORD;
      endcase
   endfunction

   function automatic logic [31:0] rnd_addr();
      int ln = int'($urandom_range(0, 3)) * DEPTH
             + int'($urandom_range(0, 31));
      return 32'(ln * LB + int'($urandom_range(0, 15)));
   endfunction

   // Issue one request at a negedge, scramble inputs while in flight,
   // return at the negedge of the following IDLE cycle.
   task automatic do_req(bit r, bit w, memop_data_type_e t,
                         logic [31:0] a, line_t d, bit hold);
      exp_t e;
      rd = r; wr = w; ty = t; addr = a; wd = d;
      e.data = model(0, w, t, a, d);
      e.cyc  = cyc + L;
      q.push_back(e);
      repeat (L) begin
         @(negedge clk);
         addr = $urandom;
         wd   = rnd_line();
         ty   = rnd_ty();
         if (hold) begin
            rd = 1'b1; wr = 1'b0;
         end else begin
            rd = 1'($urandom); wr = 1'($urandom);
         end
      end
      @(negedge clk);
      if (!hold) begin
         rd = 1'b0; wr = 1'b0;
      end
   endtask

   // Latency-1 instance: ready must follow the accept edge directly.
   task automatic req1(bit r, bit w, memop_data_type_e t,
                       logic [31:0] a, line_t d);
      line_t ex;
      rd1 = r; wr1 = w; ty1 = t; addr1 = a; wd1 = d;
      ex = model(BASE1, w, t, a, d);
      @(negedge clk);
      chk(rdy1 === 1'b1, "l1_ready", 128'(rdy1), 128'(1));
      chk(rdat1 === ex, "l1_line", rdat1, ex);
      rd1 = 1'b0; wr1 = 1'b0;
      @(negedge clk);
      chk(rdy1 === 1'b0, "l1_pulse_width", 128'(rdy1), 128'(0));
      chk(rdat1 === ex, "l1_hold", rdat1, ex);
   endtask

   // Scoreboard monitor: every ready pulse must match the oldest request.
   always @(negedge clk) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
         chk(1'b0, "missing_ready", 128'(cyc), 128'(q[0].cyc));
         void'(q.pop_front());
      end
      if (rdy === 1'b1) begin
         if (q.size() == 0) begin
            chk(1'b0, "unexpected_ready", 128'(1), 128'(0));
         end else begin
            mon_e = q.pop_front();
            chk(cyc == mon_e.cyc, "ready_cycle",
                128'(cyc), 128'(mon_e.cyc));
            chk(rdat === mon_e.data, "rd_line", rdat, mon_e.data);
            chk(bsy === 1'b1, "busy_in_resp", 128'(bsy), 128'(1));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, %0d/%0d checks passed",
               n_pass, n_chk);
      $fatal(1, "watchdog timeout");
   end

   initial begin
      line_t d;
      line_t x;

      repeat (2) @(negedge clk);
      chk(rdy === 1'b0, "rst_ready", 128'(rdy), 128'(0));
      chk(bsy === 1'b0, "rst_busy", 128'(bsy), 128'(0));
      chk(rdat === '0, "rst_rdata", rdat, '0);
      chk(rdy1 === 1'b0 && bsy1 === 1'b0, "rst_l1_flags",
          128'({rdy1, bsy1}), 128'(0));
      chk(rdat1 === '0, "rst_l1_rdata", rdat1, '0);
      rsn = 1'b0;

      for (int ln = 0; ln < 32; ln++) begin
         for (int w = 0; w < 4; w++) begin
            do_req(1'b0, 1'b1, WORD, 32'(ln * LB + w * 4), rnd_line(), 1'b0);
         end
      end

      d = {LB{8'h11}};
      for (int w = 0; w < 4; w++) begin
         do_req(1'b0, 1'b1, WORD, 32'(32'h100 + w * 4), d, 1'b0);
      end
      d = rnd_line();
      d[3] = 8'hAA;
      do_req(1'b0, 1'b1, BYTE, 32'h103, d, 1'b0);
      do_req(1'b1, 1'b0, BYTE, 32'h100, rnd_line(), 1'b0);
      x = {LB{8'h11}};
      x[3] = 8'hAA;
      chk(rdat === x, "byte_aa_line", rdat, x);

      d = rnd_line();
      d[3:0] = 32'hDEADBEEF;
      do_req(1'b0, 1'b1, WORD, 32'h100, d, 1'b0);
      do_req(1'b1, 1'b0, WORD, 32'h100, rnd_line(), 1'b0);
      x = {LB{8'h11}};
      x[3:0] = 32'hDEADBEEF;
      chk(rdat === x, "word_deadbeef_line", rdat, x);

      do_req(1'b0, 1'b1, WORD, 32'(20 * LB + 14), rnd_line(), 1'b0);
      do_req(1'b1, 1'b0, BYTE, 32'(20 * LB), rnd_line(), 1'b0);
      do_req(1'b1, 1'b0, BYTE, 32'(21 * LB), rnd_line(), 1'b0);

      rd = 1'b0; wr = 1'b1; ty = WORD;
      addr = 32'(24 * LB); wd = rnd_line();
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      rsn = 1'b1;
      @(negedge clk);
      chk(bsy === 1'b0, "abort_busy", 128'(bsy), 128'(0));
      chk(rdy === 1'b0, "abort_ready", 128'(rdy), 128'(0));
      chk(rdat === '0, "abort_rdata", rdat, '0);
      rsn = 1'b0;
      do_req(1'b1, 1'b0, WORD, 32'(24 * LB), rnd_line(), 1'b0);

      for (int i = 0; i < 6; i++) begin
         do_req(1'b1, 1'b0, rnd_ty(), rnd_addr(), rnd_line(), 1'b1);
      end
      rd = 1'b0;

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    do_req(1'b1, 1'b0, rnd_ty(), rnd_addr(), rnd_line(), 1'b0);
            2:       do_req(1'b0, 1'b1, rnd_ty(), rnd_addr(), rnd_line(), 1'b0);
            default: do_req(1'b1, 1'b1, rnd_ty(), rnd_addr(), rnd_line(), 1'b0);
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int ln = 5; ln < 7; ln++) begin
         for (int w = 0; w < 4; w++) begin
            req1(1'b0, 1'b1, WORD, 32'(ln * LB + w * 4), rnd_line());
         end
      end
      req1(1'b1, 1'b1, WORD, 32'(5 * LB + 6), rnd_line());
      req1(1'b1, 1'b0, BYTE, 32'(5 * LB), rnd_line());
      req1(1'b0, 1'b1, HALF, 32'(5 * LB + 15), rnd_line());
      req1(1'b1, 1'b0, BYTE, 32'(5 * LB), rnd_line());
      req1(1'b1, 1'b0, BYTE, 32'(6 * LB), rnd_line());

      repeat (3) @(negedge clk);
      chk(q.size() == 0, "queue_drained", 128'(q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
